// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared state encoding and PC constants for the fetch unit
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DROP    = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    localparam int PC_STEP = 4;

    // Low address bits that are forced to zero to keep the PC word aligned.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - memory handshake and instruction register bundle for the fetch unit
interface inst_fetch_if #(
    parameter int BITS      = 32,
    parameter int ADDR_BITS = 32
);
    logic                 mem_req;
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_ack;
    logic [BITS-1:0]      mem_rdata;
    logic                 ir_load;
    logic [BITS-1:0]      ir_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        output ir_load,
        output ir_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        input  ir_load,
        input  ir_data
    );
endinterface

// File: rtl/inst_fetch_pc_reg.sv
// rtl/inst_fetch_pc_reg.sv - program counter with aligned load (priority) and word increment
module pc_reg
    import fetch_pkg::*;
#(
    parameter int                   ADDR_BITS = 32,
    parameter logic [ADDR_BITS-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [ADDR_BITS-1:0] load_value,
    input  logic                 inc,
    output logic [ADDR_BITS-1:0] pc,
    output logic [ADDR_BITS-1:0] pc_plus
);

    localparam logic [ADDR_BITS-1:0] LOW_MASK = {{(ADDR_BITS-2){1'b0}}, ALIGN_MASK};

    assign pc_plus = pc + ADDR_BITS'(PC_STEP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value & ~LOW_MASK;
        end else if (inc) begin
            pc <= pc_plus;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch producer; FETCH_COUNT_EN adds a delivered-word counter
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int                   BITS      = 32,
    parameter int                   ADDR_BITS = 32,
    parameter logic [ADDR_BITS-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [ADDR_BITS-1:0] redirect_pc,
    inst_fetch_if.master         bus,
    output logic [ADDR_BITS-1:0] pc_out,
    output logic [31:0]          fetch_count
);

    state_t               state, state_nxt;
    logic [ADDR_BITS-1:0] pc, pc_plus, addr_q;
    logic [BITS-1:0]      buffer;
    logic                 deliver_fire, capture, issue_from_idle;

    pc_reg #(
        .ADDR_BITS (ADDR_BITS),
        .RESET_PC  (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (redirect),
        .load_value (redirect_pc),
        .inc        (deliver_fire),
        .pc         (pc),
        .pc_plus    (pc_plus)
    );

    assign deliver_fire = (state == S_DELIVER) && !stall && !redirect;

    always_comb begin
        state_nxt       = state;
        capture         = 1'b0;
        issue_from_idle = 1'b0;
        case (state)
            S_IDLE: begin
                if (!redirect && !stall) begin
                    issue_from_idle = 1'b1;
                    state_nxt       = S_REQ;
                end
            end
            S_REQ: begin
                // A redirect with a same-cycle ack finishes the bus beat, so nothing is left to drain.
                if (redirect) begin
                    state_nxt = bus.mem_ack ? S_IDLE : S_DROP;
                end else if (bus.mem_ack) begin
                    capture   = 1'b1;
                    state_nxt = S_DELIVER;
                end
            end
            S_DROP: begin
                if (bus.mem_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DELIVER: begin
                if (redirect) begin
                    state_nxt = S_IDLE;
                end else if (!stall) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            addr_q <= RESET_PC;
            buffer <= '0;
            pc_out <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (issue_from_idle) begin
                addr_q <= pc;
            end else if (deliver_fire) begin
                addr_q <= pc_plus;
            end
            if (capture) begin
                buffer <= bus.mem_rdata;
            end
            if (deliver_fire) begin
                pc_out <= pc;
            end
        end
    end

    assign bus.mem_req  = (state == S_REQ) || (state == S_DROP);
    assign bus.mem_addr = addr_q;
    assign bus.ir_data  = buffer;
    assign bus.ir_load  = deliver_fire;

`ifdef FETCH_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (deliver_fire) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign fetch_count = count_q;
`else
    assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc_out;
    logic [31:0] fetch_count;
    int          checks = 0;
    int          errors = 0;

    inst_fetch_if #(.BITS(32), .ADDR_BITS(32)) bus ();

    inst_fetch #(.BITS(32), .ADDR_BITS(32), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus),
        .pc_out      (pc_out),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ack(input logic a, input logic [31:0] d);
        bus.mem_ack   = a;
        bus.mem_rdata = d;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        ack(1'b0, 32'h0);
        tick(); tick();
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_ir_load", bus.ir_load, 1'b0);
        chk("rst_ir_data", bus.ir_data, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_count", fetch_count, 32'h0);

        // zero-wait fetch from address 0
        rst_n = 1'b1;
        tick();
        chk("t1_req", bus.mem_req, 1'b1);
        chk("t1_addr", bus.mem_addr, 32'h0);
        ack(1'b1, 32'h0000_0013);
        tick();
        ack(1'b0, 32'h0); #1;
        chk("t1_load", bus.ir_load, 1'b1);
        chk("t1_data", bus.ir_data, 32'h0000_0013);
        tick();
        chk("t1_pc_out", pc_out, 32'h0);
        chk("t1_next_req", bus.mem_req, 1'b1);
        chk("t1_next_addr", bus.mem_addr, 32'h4);

        // word at 4, then 3-cycle ack delay at 8
        ack(1'b1, 32'h0000_00A0);
        tick();
        ack(1'b0, 32'h0); #1;
        chk("t2_load4", bus.ir_load, 1'b1);
        chk("t2_data4", bus.ir_data, 32'h0000_00A0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t2_wait_req", bus.mem_req, 1'b1);
            chk("t2_wait_addr", bus.mem_addr, 32'h8);
            chk("t2_wait_noload", bus.ir_load, 1'b0);
            tick();
        end
        ack(1'b1, 32'h0000_00B8); #1;
        chk("t2_ack_addr", bus.mem_addr, 32'h8);
        tick();
        ack(1'b0, 32'h0); #1;
        chk("t2_load8", bus.ir_load, 1'b1);
        chk("t2_data8", bus.ir_data, 32'h0000_00B8);
        tick();
        chk("t2_pc_out", pc_out, 32'h8);
        chk("t2_noload_after", bus.ir_load, 1'b0);

        // stall held 4 cycles in delivery of word at 0xC
        chk("t3_addr", bus.mem_addr, 32'hC);
        ack(1'b1, 32'h0000_00C0);
        tick();
        ack(1'b0, 32'h0);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_stall_noload", bus.ir_load, 1'b0);
            chk("t3_stall_data", bus.ir_data, 32'h0000_00C0);
            tick();
        end
        stall = 1'b0; #1;
        chk("t3_release_load", bus.ir_load, 1'b1);
        tick();
        chk("t3_pc_out", pc_out, 32'hC);
        chk("t3_next_addr", bus.mem_addr, 32'h10);

        // redirect to 0x103 while waiting at 0x10; stale ack two cycles later
        redirect = 1'b1; redirect_pc = 32'h103; #1;
        chk("t4_redir_noload", bus.ir_load, 1'b0);
        tick();
        redirect = 1'b0;
        chk("t4_drop_req", bus.mem_req, 1'b1);
        chk("t4_drop_addr", bus.mem_addr, 32'h10);
        tick();
        ack(1'b1, 32'hDEAD_BEEF); #1;
        chk("t4_stale_noload", bus.ir_load, 1'b0);
        tick();
        ack(1'b0, 32'h0); #1;
        chk("t4_idle_req", bus.mem_req, 1'b0);
        chk("t4_idle_noload", bus.ir_load, 1'b0);
        tick();
        chk("t4_new_req", bus.mem_req, 1'b1);
        chk("t4_new_addr", bus.mem_addr, 32'h100);
        ack(1'b1, 32'h0000_1234);
        tick();
        ack(1'b0, 32'h0); #1;
        chk("t4_load", bus.ir_load, 1'b1);
        chk("t4_data", bus.ir_data, 32'h0000_1234);
        tick();
        chk("t4_pc_out", pc_out, 32'h100);
`ifdef FETCH_COUNT_EN
        chk("t4_count5", fetch_count, 32'd5);
`else
        chk("t4_count_off", fetch_count, 32'd0);
`endif

        // redirect together with ack in S_REQ
        chk("t5_addr", bus.mem_addr, 32'h104);
        redirect = 1'b1; redirect_pc = 32'h200;
        ack(1'b1, 32'h0000_5555); #1;
        chk("t5a_noload", bus.ir_load, 1'b0);
        tick();
        redirect = 1'b0;
        ack(1'b0, 32'h0); #1;
        chk("t5a_idle_req", bus.mem_req, 1'b0);
        chk("t5a_idle_noload", bus.ir_load, 1'b0);
        tick();
        chk("t5a_new_addr", bus.mem_addr, 32'h200);
        ack(1'b1, 32'h0000_2000);
        tick();
        ack(1'b0, 32'h0);
        // redirect and stall together in S_DELIVER
        redirect = 1'b1; redirect_pc = 32'h300; stall = 1'b1; #1;
        chk("t5b_noload", bus.ir_load, 1'b0);
        tick();
        redirect = 1'b0; stall = 1'b0; #1;
        chk("t5b_idle_req", bus.mem_req, 1'b0);
        chk("t5b_pc_out_kept", pc_out, 32'h100);
        tick();
        chk("t5b_new_addr", bus.mem_addr, 32'h300);
        ack(1'b1, 32'h0000_3000);
        tick();
        ack(1'b0, 32'h0); #1;
        chk("t5b_load", bus.ir_load, 1'b1);
        chk("t5b_data", bus.ir_data, 32'h0000_3000);
        tick();
        chk("t5b_pc_out", pc_out, 32'h300);

        // redirect to top of address space and wrap
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect = 1'b0;
        ack(1'b1, 32'h0);
        tick();
        ack(1'b0, 32'h0);
        tick();
        chk("t6_top_addr", bus.mem_addr, 32'hFFFF_FFFC);
        ack(1'b1, 32'h0000_F0F0);
        tick();
        ack(1'b0, 32'h0); #1;
        chk("t6_load", bus.ir_load, 1'b1);
        tick();
        chk("t6_pc_out", pc_out, 32'hFFFF_FFFC);
        chk("t6_wrap_addr", bus.mem_addr, 32'h0);
        chk("t6_wrap_req", bus.mem_req, 1'b1);
`ifdef FETCH_COUNT_EN
        chk("t6_count7", fetch_count, 32'd7);
`else
        chk("t6_count_off", fetch_count, 32'd0);
`endif

        // reset while a request is outstanding
        rst_n = 1'b0;
        tick();
        chk("t7_rst_req", bus.mem_req, 1'b0);
        chk("t7_rst_count", fetch_count, 32'd0);
        chk("t7_rst_pc_out", pc_out, 32'h0);
        chk("t7_rst_addr", bus.mem_addr, 32'h0);
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Fetch-side producer for the 32-bit instruction register: handshakes with instruction memory and delivers one word per fetch.
- Sits between the instruction-memory port and the instruction register.
- Holds the PC and issues read requests, buffers the returned word, then drives ir_data and pulses ir_load for exactly one cycle.
- Supports pipeline stall and PC redirect (branch/jump), discarding stale responses.

Parameters:
BITS, 32, instruction/data width (matches instruction register)
ADDR_BITS, 32, PC / memory address width
RESET_PC, 0, PC value after reset (word aligned)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
stall  in  1  hold delivery and new requests
redirect  in  1  load redirect_pc into PC, cancel in-flight fetch
redirect_pc  in  ADDR_BITS  redirect target; bits [1:0] ignored (forced 0)
mem_req  out  1  read request to instruction memory
mem_addr  out  ADDR_BITS  request address, stable while mem_req=1
mem_ack  in  1  memory response valid (only meaningful while mem_req=1)
mem_rdata  in  BITS  response word, sampled when mem_ack=1
ir_load  out  1  load strobe to instruction register, one-cycle pulse
ir_data  out  BITS  word to instruction register
pc_out  out  ADDR_BITS  address of word most recently delivered
fetch_count  out  32  delivered-instruction counter (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at posedge): state=S_IDLE, pc=RESET_PC, addr_q=RESET_PC, buffer=0, pc_out=RESET_PC. Outputs mem_req=0, ir_load=0, ir_data=0.
- Reset mid-transaction abandons the request; memory shares rst_n.
- States: S_IDLE, S_REQ, S_DROP, S_DELIVER.
- Outputs: mem_req=1 in S_REQ/S_DROP. mem_addr=addr_q always. ir_data=buffer. ir_load=(state==S_DELIVER)&&!stall&&!redirect (combinational).
- S_IDLE:
  - redirect: pc<=redirect_pc, stay.
  - else if !stall: addr_q<=pc, go S_REQ.
  - else stay.
- S_REQ:
  - redirect: pc<=redirect_pc. With mem_ack the same cycle, go S_IDLE (word dropped); without it, go S_DROP.
  - else if mem_ack: buffer<=mem_rdata, go S_DELIVER.
  - else stay; addr_q held.
  - stall does not withdraw an issued request.
- S_DROP:
  - mem_req stays 1 at old addr_q until mem_ack, then go S_IDLE (data discarded).
  - Further redirects update pc and stay in S_DROP.
- S_DELIVER:
  - redirect: discard buffer, pc<=redirect_pc, go S_IDLE. Redirect beats stall.
  - else if stall: hold, ir_load=0.
  - else: ir_load=1, pc_out<=pc, pc<=pc+4, addr_q<=pc+4, go S_REQ.
- Latency: from S_IDLE with stall=0 and zero-wait memory:
  - cycle0 S_IDLE
  - cycle1 mem_req=1, mem_ack=1
  - cycle2 ir_load=1
  - cycle3 next mem_req
  - Steady throughput: 1 word / 2 cycles.
- Arithmetic: pc+4 modulo 2^ADDR_BITS; wrap from max aligned address to 0 is legal.
- mem_ack outside S_REQ/S_DROP is ignored.

Optional Feature:
- Macro FETCH_COUNT_EN.
- Defined: 32-bit counter cleared by reset, increments on every cycle with ir_load=1, wraps at 2^32, drives fetch_count.
- Undefined: no counter flops; fetch_count tied to 0.

Decomposition:
- Package fetch_pkg:
  - state encoding (S_IDLE=2'd0, S_REQ=2'd1, S_DROP=2'd2, S_DELIVER=2'd3)
  - PC_STEP=4
  - alignment mask constant
- Sub-module pc_reg: ADDR_BITS register with sync active-low reset to RESET_PC, load (redirect, low bits zeroed) and increment enables; load has priority.

Test Plan:
- Reset then stall=0, zero-wait memory returning 0x00000013 at addr 0 -> mem_req at cycle1, addr 0; ir_load pulse cycle2 with ir_data=0x00000013, pc_out=0; next mem_addr=4.
- mem_ack delayed 3 cycles -> mem_req and mem_addr=0x8 held stable all 3 cycles; single ir_load after ack.
- stall=1 while in S_DELIVER for 4 cycles -> ir_load=0 and ir_data stable; ir_load=1 the cycle stall falls.
- redirect to 0x103 while S_REQ waiting (ack 2 cycles later, rdata 0xDEADBEEF) -> stale word never loaded; next request addr 0x100; pc_out=0x100 at its delivery.
- redirect with mem_ack same cycle in S_REQ, and redirect+stall in S_DELIVER -> no ir_load; next request at redirect target.
- redirect to 0xFFFFFFFC, deliver -> following mem_addr=0x0. With FETCH_COUNT_EN, 5 deliveries -> fetch_count=5; reset mid-wait -> fetch_count=0, mem_req=0.
